// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS-style fetch front end.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold, load, or collapse to a bubble when neither is asserted.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (hold) begin
      instr_d    = instr_q;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end else begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and stall hold buffer feeding the IF/ID register.
//   state | meaning
//   FETCH | request outstanding on imem, address = PCF
//   HELD  | word captured during a stall, no request until the stall clears
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;

  logic         ifid_hold, ifid_load;
  logic [31:0]  ifid_instr;
  logic [31:0]  pc_plus4;
  logic [31:0]  branch_pc;
  logic         accept;
  logic         unused_target_lsbs;

  assign pc_plus4           = pcf_q + 32'd4;
  assign branch_pc          = {BranchTargetD[31:2], 2'b00};
  assign unused_target_lsbs = ^BranchTargetD[1:0];

  assign imem_req  = (state_q == FETCH) && !rst;
  assign imem_addr = pcf_q;
  assign accept    = imem_req && imem_ready;

  // Stall outranks the branch redirect; the hazard unit re-presents the branch later.
  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    ifid_hold   = 1'b1;
    ifid_load   = 1'b0;
    ifid_instr  = imem_rdata;
    case (state_q)
      FETCH: begin
        if (Stall) begin
          if (accept) begin
            buf_d       = imem_rdata;
            buf_valid_d = 1'b1;
            state_d     = HELD;
          end
        end else if (BranchTakenD) begin
          pcf_d       = branch_pc;
          buf_valid_d = 1'b0;
          ifid_hold   = 1'b0;
        end else if (accept) begin
          pcf_d     = pc_plus4;
          ifid_hold = 1'b0;
          ifid_load = 1'b1;
        end else begin
          ifid_hold = 1'b0;
        end
      end
      HELD: begin
        if (!Stall) begin
          state_d     = FETCH;
          buf_valid_d = 1'b0;
          ifid_hold   = 1'b0;
          if (BranchTakenD) begin
            pcf_d = branch_pc;
          end else begin
            ifid_instr = buf_q;
            ifid_load  = buf_valid_q;
            if (buf_valid_q) pcf_d = pc_plus4;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pcf_q       <= RESET_PC;
      buf_q       <= NOP_INSTR;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .hold        (ifid_hold),
    .load        (ifid_load),
    .instr_in    (ifid_instr),
    .pc_plus4_in (pc_plus4),
    .instr       (InstrD),
    .pc_plus4    (PCPlus4D),
    .valid       (ValidD)
  );

  assign rsD = InstrD[25:21];
  assign rtD = InstrD[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-reset instance plus one reset at the top of memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ready;
  logic [31:0] salt;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] instr0, instr1;
  logic [31:0] pc4_0, pc4_1;
  logic        valid0, valid1;
  logic [4:0]  rs0, rt0, rs1, rt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [4:0] idx;
    idx = a[6:2];
    return {6'b001000, idx, idx + 5'd1, a[15:0]};
  endfunction

  assign rdata0 = mem_word(addr0) ^ salt;
  assign rdata1 = mem_word(addr1);

  fetch_stage dut0 (
    .clk(clk), .rst(rst), .Stall(stall), .BranchTakenD(br_taken),
    .BranchTargetD(br_target), .imem_req(req0), .imem_addr(addr0),
    .imem_ready(ready), .imem_rdata(rdata0), .InstrD(instr0),
    .PCPlus4D(pc4_0), .ValidD(valid0), .rsD(rs0), .rtD(rt0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .Stall(stall), .BranchTakenD(br_taken),
    .BranchTargetD(br_target), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(ready), .imem_rdata(rdata1), .InstrD(instr1),
    .PCPlus4D(pc4_1), .ValidD(valid1), .rsD(rs1), .rtD(rt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    ready = 1'b1; salt = 32'h0;
    step(); step();
    check("rst_req",    {31'b0, req0},   32'h0);
    check("rst_addr",   addr0,           32'h0);
    check("rst_valid",  {31'b0, valid0}, 32'h0);
    check("rst_instr",  instr0,          32'h0);
    check("rst_pc4",    pc4_0,           32'h0);
    check("rst_addr1",  addr1,           32'hFFFF_FFFC);

    rst = 1'b0; #1;
    check("first_req",   {31'b0, req0},   32'h1);
    check("first_addr",  addr0,           32'h0);
    check("first_valid", {31'b0, valid0}, 32'h0);

    step();
    check("seq_addr4",  addr0,           32'h4);
    check("seq_valid",  {31'b0, valid0}, 32'h1);
    check("seq_pc4",    pc4_0,           32'h4);
    check("seq_instr",  instr0,          mem_word(32'h0));
    check("seq_rt",     {27'b0, rt0},    32'h1);
    check("wrap_addr",  addr1,           32'h0);
    check("wrap_pc4",   pc4_1,           32'h0);

    step();
    check("seq_addr8",  addr0, 32'h8);
    check("seq_pc4_8",  pc4_0, 32'h8);

    // Two not-ready cycles at PC=8.
    ready = 1'b0;
    step();
    check("nr1_valid", {31'b0, valid0}, 32'h0);
    check("nr1_addr",  addr0,           32'h8);
    step();
    check("nr2_valid", {31'b0, valid0}, 32'h0);
    check("nr2_pc4",   pc4_0,           32'h0);
    check("nr2_addr",  addr0,           32'h8);
    ready = 1'b1;
    step();
    check("nr_resume_instr", instr0, mem_word(32'h8));
    check("nr_resume_pc4",   pc4_0,  32'hC);
    check("nr_resume_addr",  addr0,  32'hC);

    // Three-cycle stall at PC=C; word is captured on the first stalled edge.
    stall = 1'b1;
    step();
    salt = 32'h0000_5A5A;
    check("st1_req",   {31'b0, req0}, 32'h0);
    check("st1_instr", instr0,        mem_word(32'h8));
    check("st1_pc4",   pc4_0,         32'hC);
    step();
    check("st2_req",   {31'b0, req0}, 32'h0);
    step();
    check("st3_pc4",   pc4_0,         32'hC);
    check("st3_addr",  addr0,         32'hC);
    stall = 1'b0; #1;
    check("st_rel_req", {31'b0, req0}, 32'h0);
    step();
    salt = 32'h0;
    check("held_instr", instr0,          mem_word(32'hC));
    check("held_valid", {31'b0, valid0}, 32'h1);
    check("held_pc4",   pc4_0,           32'h10);
    check("held_rs",    {27'b0, rs0},    32'h3);
    check("held_next",  addr0,           32'h10);

    // Stall and branch together: no redirect, IF/ID held.
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200;
    step();
    check("sb_addr",  addr0,  32'h10);
    check("sb_pc4",   pc4_0,  32'h10);
    check("sb_instr", instr0, mem_word(32'hC));

    // Branch released from HELD, unaligned target.
    stall = 1'b0; br_target = 32'h0000_0103;
    step();
    br_taken = 1'b0;
    check("br_addr",  addr0,           32'h100);
    check("br_valid", {31'b0, valid0}, 32'h0);
    check("br_req",   {31'b0, req0},   32'h1);
    step();
    check("br_next_valid", {31'b0, valid0}, 32'h1);
    check("br_next_pc4",   pc4_0,           32'h104);
    check("br_next_instr", instr0,          mem_word(32'h100));

    // Branch taken from FETCH.
    br_taken = 1'b1; br_target = 32'h0000_0207;
    step();
    br_taken = 1'b0;
    check("brf_addr",  addr0,           32'h204);
    check("brf_valid", {31'b0, valid0}, 32'h0);
    step();
    check("brf_pc4",   pc4_0,           32'h208);

    // Reset while HELD discards the buffered word.
    stall = 1'b1;
    step();
    check("rh_req_held", {31'b0, req0}, 32'h0);
    rst = 1'b1; #1;
    check("rh_req_rst",  {31'b0, req0}, 32'h0);
    step();
    check("rh_addr",  addr0,           32'h0);
    check("rh_valid", {31'b0, valid0}, 32'h0);
    check("rh_instr", instr0,          32'h0);
    check("rh_pc4",   pc4_0,           32'h0);
    rst = 1'b0; stall = 1'b0; #1;
    check("rh_req_after", {31'b0, req0}, 32'h1);
    step();
    check("rh_first_instr", instr0, mem_word(32'h0));
    check("rh_first_pc4",   pc4_0,  32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Stall  input  1  hazard-unit stall; holds PCF and IF/ID register.
REQ-005 BranchTakenD  input  1  branch resolved taken in Decode; redirect fetch.
REQ-006 BranchTargetD  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch address, equals PCF.
REQ-009 imem_ready  input  1  response valid this cycle when imem_req=1.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-011 InstrD  output  32  IF/ID instruction register.
REQ-012 PCPlus4D  output  32  IF/ID PC+4 register.
REQ-013 ValidD  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 rsD, rtD  output  5 each  InstrD[25:21] and InstrD[20:16], combinational from the IF/ID register.

Function
REQ-015 FSM states: FETCH (request outstanding), HELD (word captured during Stall, no request).
REQ-016 FETCH: imem_req=1, imem_addr=PCF; a request is not committed, so the address may change or the request may drop before imem_ready.
REQ-017 FETCH, accept (imem_ready=1), Stall=0, BranchTakenD=0: IF/ID <= {imem_rdata, PCF+4, valid 1}; PCF <= PCF+4; stay FETCH.
REQ-018 FETCH, imem_ready=0, Stall=0, BranchTakenD=0: IF/ID <= bubble (InstrD=0, PCPlus4D=0, ValidD=0); PCF held.
REQ-019 FETCH, Stall=1: IF/ID and PCF held; if imem_ready=1, the word is captured into the hold buffer and the state moves to HELD; otherwise remain in FETCH.
REQ-020 HELD: imem_req=0; while Stall=1 everything is held; when Stall=0, IF/ID <= {buffer, PCF+4, valid 1}, PCF <= PCF+4, next state FETCH.
REQ-021 BranchTakenD=1 with Stall=0, in any state: PCF <= {BranchTargetD[31:2],2'b00}; IF/ID <= bubble (the wrong-path word is discarded); hold buffer invalidated; next state FETCH.
REQ-022 Stall has priority over BranchTakenD; a BranchTakenD that arrives while Stall=1 is ignored (the hazard unit re-presents it after the stall).
REQ-023 PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; PCF[1:0] is always 00.
REQ-024 Fetch-to-Decode latency is one cycle from accept; with imem_ready tied high and no stall or branch, throughput is one instruction per cycle.

Reset
REQ-025 While rst=1: PCF=RESET_PC, state=FETCH, buffer invalid, InstrD=0, PCPlus4D=0, ValidD=0, imem_req=0.
REQ-026 rst dominates Stall and BranchTakenD; reset mid-HELD discards the buffered word; the first request is issued in the cycle after rst deasserts.

Structure
REQ-027 The package mips_pkg holds RESET_PC default, NOP_INSTR (32'h0000_0000), and the fetch-state enum.
REQ-028 The IF/ID register (hold, clear-to-bubble, load) is the sub-module if_id_reg; the PC, FSM, and hold buffer stay in fetch_stage.

Verification
REQ-029 Reset release, imem_ready=1 constantly -> imem_addr sequence 0,4,8,C; ValidD first high one cycle after the first accept, with PCPlus4D=4.
REQ-030 Stall=1 for 3 cycles with imem_ready=1 -> state HELD; imem_req=0; InstrD/PCPlus4D unchanged; after the stall the buffered word appears in InstrD with no re-fetch of its address.
REQ-031 BranchTakenD=1, BranchTargetD=32'h0000_0103 -> next imem_addr=32'h0000_0100; next ValidD=0; the following ValidD=1 has PCPlus4D=32'h0000_0104.
REQ-032 Stall=1 and BranchTakenD=1 in the same cycle -> PCF and IF/ID unchanged, no redirect.
REQ-033 imem_ready low for 2 cycles at PC=8 -> two bubbles (ValidD=0); imem_addr held at 8; then normal advance.
REQ-034 RESET_PC=32'hFFFF_FFFC, imem_ready=1 -> addresses FFFF_FFFC then 0000_0000; rst asserted while in HELD -> all outputs return to their reset values the next cycle.
